data_mem_responder: RTL

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Word-addressed data memory behind a valid/ready request/response handshake with fixed response latency.
// Optional per-byte write strobes (req_be) are enabled by defining DMEM_BYTE_STROBE_EN.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
`ifdef DMEM_BYTE_STROBE_EN
  input  logic [3:0]  req_be,
`endif
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] mem_q [DEPTH_WORDS];

  logic             accept;
  logic             enter_resp;
  logic             eff_write;
  logic [31:0]      eff_addr;
  logic [31:0]      eff_wdata;
  logic             addr_err;
  logic [IDX_W-1:0] idx;
`ifdef DMEM_BYTE_STROBE_EN
  logic [3:0]       be_q;
  logic [3:0]       eff_be;
`endif

  assign req_ready = (state_q == IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  // With LATENCY==1 the array is accessed on the accept edge itself, before the latches hold the request.
  assign eff_write = (state_q == IDLE) ? req_write : write_q;
  assign eff_addr  = (state_q == IDLE) ? req_addr  : addr_q;
  assign eff_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
`ifdef DMEM_BYTE_STROBE_EN
  assign eff_be    = (state_q == IDLE) ? req_be    : be_q;
`endif

  assign addr_err   = (eff_addr[1:0] != 2'b00) ||
                      ({2'b00, eff_addr[31:2]} >= 32'(DEPTH_WORDS));
  assign idx        = eff_addr[IDX_W+1:2];
  assign enter_resp = (state_d == RESP) && (state_q != RESP) && !rst;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(LATENCY - 2);
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Response fields are captured once on entry to RESP and then held until the handshake.
  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (enter_resp) begin
      err_d   = addr_err;
      rdata_d = (addr_err || eff_write) ? 32'd0 : mem_q[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      write_q <= req_write;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
`ifdef DMEM_BYTE_STROBE_EN
      be_q    <= req_be;
`endif
    end
  end

  // Array contents are deliberately outside reset.
  always_ff @(posedge clk) begin
    if (enter_resp && eff_write && !addr_err) begin
`ifdef DMEM_BYTE_STROBE_EN
      for (int b = 0; b < 4; b++) begin
        if (eff_be[b]) mem_q[idx][8*b +: 8] <= eff_wdata[8*b +: 8];
      end
`else
      mem_q[idx] <= eff_wdata;
`endif
    end
  end

  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule
